fft_bin_reorder: RTL and testbench
==================================

# fft_bin_reorder

Producer side of the STFT-to-power interface. Accepts the FFT core's bit-reversed output stream, one complex sample per cycle, and buffers each frame in a ping-pong RAM. It then emits the non-redundant bins 0..NFFT/2 in natural order as separate real/imag words plus a valid strobe, which connect directly to power_calc. The block has no backpressure; power_calc accepts one bin per cycle unconditionally.

## Interface
- IW, 18: width of each real/imag component, two's complement.
- NFFT, 512: FFT size; power of two, ≥ 8.
- AW, $clog2(NFFT) (derived, localparam): input index width.
- BW, $clog2(NFFT/2+1) (derived, localparam): output bin index width.

- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fft_data_il  in  2*IW  {real[2*IW-1:IW], imag[IW-1:0]}, bit-reversed order.
- fft_valid_il  in  1  fft_data_il valid this cycle.
- fft_last_il  in  1  qualifies the final sample of a frame; ignored unless fft_valid_il.
- real_il... n/a; outputs follow.
- real_ol  out  IW  real part of current bin.
- imag_ol  out  IW  imaginary part of current bin.
- valid_ol  out  1  bin valid; drives power_calc valid_il.
- bin_ol  out  BW  natural-order bin index 0..NFFT/2.
- last_ol  out  1  high with bin NFFT/2 only.
- err_ol  out  1  one-cycle pulse on frame-alignment error.

## Operation
- Write side: counter wr_cnt (AW bits) counts accepted samples (fft_valid_il=1).
  - Target bin is bitrev_AW(wr_cnt).
  - If the target bin is ≤ NFFT/2, write to the write bank at that address; otherwise discard (conjugate-symmetric half).
- Frame end: the accepted sample where wr_cnt==NFFT-1 and fft_last_il=1.
  - Write bank toggles and a read of the just-filled bank is launched.
  - wr_cnt returns to 0.
- Alignment error: either condition below causes err_ol to pulse the next cycle, wr_cnt to go to 0, the partial frame to be discarded, and no bank swap or read launch.
  - fft_last_il=1 with wr_cnt≠NFFT-1.
  - wr_cnt==NFFT-1 with fft_last_il=0.
- Each RAM bank holds NFFT/2+1 entries of 2*IW bits. Synchronous read, 1-cycle latency. Read and write may hit different banks in the same cycle.
- Read FSM:
  - IDLE: go to READ on frame end; rd_addr←0.
  - READ: rd_addr increments each cycle. After issuing address NFFT/2, go to DRAIN.
  - DRAIN: one cycle for the final RAM output, then back to IDLE.
- Output registers load RAM data, a delayed rd_addr (→ bin_ol) and a delayed read-issue flag (→ valid_ol).
- last_ol = valid_ol && bin_ol==NFFT/2.
- Overlap: a read lasts NFFT/2+2 cycles, and the next frame end is ≥ NFFT cycles later. The read bank is therefore never overwritten mid-read; no overflow logic is required.
- Data is passed through bit-exact; no scaling or rounding.

## Timing
- Reset (rst=1 at posedge): valid_ol=0, last_ol=0, err_ol=0, real_ol=0, imag_ol=0, bin_ol=0, wr_cnt=0, write bank=0, FSM=IDLE.
- Reset mid-frame: partial write discarded. Reset mid-read: output stops the next cycle with valid_ol=0, and the remaining bins are lost.
- Latency: last sample accepted at edge E0. Bin 0 appears with valid_ol=1 after edge E0+2. Bin k appears after edge E0+2+k.
- valid_ol stays high for exactly NFFT/2+1 consecutive cycles per frame, with no gaps.
- Gaps in fft_valid_il: wr_cnt holds, and the frame simply completes later.
- Back-to-back frames: the first sample of the next frame may arrive in the cycle right after E0. It is written to the other bank with no stall.
- err_ol: high for exactly one cycle, after the edge on which the error sample was accepted. valid_ol is unaffected by the error.

## Test plan
- Bench uses NFFT=8, IW=18.
- Single frame: input real=k, imag=−k for k=0..7, last at k=7. Expected output after E0+2..E0+6:
  - bins 0..4 with real = 0, 4, 2, 6, 1 and imag = 0, −4, −2, −6, −1;
  - last_ol only with bin 4; err_ol=0.
- Back-to-back frames at full rate: frame A real=k, frame B real=k+100. Expected two 5-cycle bursts separated by 3 idle cycles; frame B bins carry real 100, 104, 102, 106, 101.
- Gapped input: fft_valid_il toggling 1,0,1,0. Expected output values identical to the single-frame test; first valid_ol 2 cycles after the final accepted sample.
- Early last: fft_last_il with the 4th accepted sample (wr_cnt=3). Expected: err_ol pulses once, no output burst; a following clean frame outputs correctly.
- Missing last: 8 samples without fft_last_il. Expected: err_ol pulse, no output; the next clean frame is correct.
- Reset mid-read: rst asserted after bin 2. Expected: valid_ol=0 next cycle and all outputs 0; a clean frame afterwards reproduces the single-frame result.

Source files
------------

// File: rtl/fft_bin_reorder.sv
// fft_bin_reorder: reorders bit-reversed FFT output into natural-order
// bins 0..NFFT/2 using a ping-pong RAM; feeds power_calc directly.
module fft_bin_reorder #(
  parameter  int IW   = 18,
  parameter  int NFFT = 512,
  localparam int AW   = $clog2(NFFT),
  localparam int BW   = $clog2(NFFT/2+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2*IW-1:0] fft_data_il,
  input  logic          fft_valid_il,
  input  logic          fft_last_il,
  output logic [IW-1:0] real_ol,
  output logic [IW-1:0] imag_ol,
  output logic          valid_ol,
  output logic [BW-1:0] bin_ol,
  output logic          last_ol,
  output logic          err_ol
);

  localparam int DEPTH = NFFT/2 + 1;
  localparam logic [AW-1:0] LAST_CNT = AW'(NFFT-1);
  localparam logic [AW-1:0] HALF_A   = AW'(NFFT/2);
  localparam logic [BW-1:0] HALF_B   = BW'(NFFT/2);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   tgt;
  logic            wr_bank;
  logic            rd_bank;
  logic [BW-1:0]   rd_addr;
  logic [BW-1:0]   rd_addr_nx;
  logic [BW-1:0]   addr_d;
  logic            iss;
  logic            iss_d;
  logic [2*IW-1:0] ram_q;
  logic [2*IW-1:0] mem [2][DEPTH];

  logic at_end;
  logic frame_end;
  logic align_err;

  // bit-reverse the input counter to get the natural-order bin
  always_comb begin
    tgt = '0;
    for (int i = 0; i < AW; i++) tgt[i] = wr_cnt[AW-1-i];
  end

  assign at_end    = (wr_cnt == LAST_CNT);
  assign frame_end = fft_valid_il && at_end && fft_last_il;
  assign align_err = fft_valid_il && (fft_last_il != at_end);

  // input counter, bank select and alignment error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      err_ol  <= 1'b0;
    end else begin
      err_ol <= align_err;
      if (frame_end || align_err) wr_cnt <= '0;
      else if (fft_valid_il)      wr_cnt <= wr_cnt + AW'(1);
      if (frame_end) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end
    end
  end

  // RAM write; upper conjugate half is dropped
  always_ff @(posedge clk) begin
    if (!rst && fft_valid_il && (tgt <= HALF_A))
      mem[wr_bank][tgt] <= fft_data_il;
  end

  // RAM synchronous read port
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_bank][rd_addr];
  end

  // read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
    end else begin
      state   <= state_nx;
      rd_addr <= rd_addr_nx;
    end
  end

  // read FSM next state and read issue
  always_comb begin
    state_nx   = state;
    rd_addr_nx = rd_addr;
    iss        = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_end) begin
          state_nx   = READ;
          rd_addr_nx = '0;
        end
      end
      READ: begin
        iss        = 1'b1;
        rd_addr_nx = rd_addr + BW'(1);
        if (rd_addr == HALF_B) state_nx = DRAIN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // align address/issue flag with RAM output
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_d  <= 1'b0;
      addr_d <= '0;
    end else begin
      iss_d  <= iss;
      addr_d <= rd_addr;
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_ol <= 1'b0;
      bin_ol   <= '0;
      real_ol  <= '0;
      imag_ol  <= '0;
    end else begin
      valid_ol <= iss_d;
      if (iss_d) begin
        bin_ol  <= addr_d;
        real_ol <= ram_q[2*IW-1:IW];
        imag_ol <= ram_q[IW-1:0];
      end
    end
  end

  assign last_ol = valid_ol && (bin_ol == HALF_B);

endmodule

// File: tb/tb_fft_bin_reorder.sv
// tb_fft_bin_reorder: directed checks of bin reordering, latency,
// back-to-back frames, alignment errors and reset mid-read.
module tb_fft_bin_reorder;

  localparam int IW   = 18;
  localparam int NFFT = 8;
  localparam int BW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*IW-1:0] fft_data_il = '0;
  logic            fft_valid_il = 1'b0;
  logic            fft_last_il = 1'b0;
  logic [IW-1:0]   real_ol;
  logic [IW-1:0]   imag_ol;
  logic            valid_ol;
  logic [BW-1:0]   bin_ol;
  logic            last_ol;
  logic            err_ol;

  fft_bin_reorder #(.IW(IW), .NFFT(NFFT)) dut (
    .clk          (clk),
    .rst          (rst),
    .fft_data_il  (fft_data_il),
    .fft_valid_il (fft_valid_il),
    .fft_last_il  (fft_last_il),
    .real_ol      (real_ol),
    .imag_ol      (imag_ol),
    .valid_ol     (valid_ol),
    .bin_ol       (bin_ol),
    .last_ol      (last_ol),
    .err_ol       (err_ol)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc  = 0;
  int vcnt = 0;
  int ecnt = 0;
  int q_re[$];
  int q_cyc[$];
  int perm[5] = '{0, 4, 2, 6, 1};

  // log output activity for multi-frame checks
  always @(negedge clk) begin
    cyc++;
    if (valid_ol === 1'b1) begin
      vcnt++;
      q_re.push_back(int'(real_ol));
      q_cyc.push_back(cyc);
    end
    if (err_ol === 1'b1) ecnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int re, input int im,
                       input logic v, input logic l);
    fft_data_il  = {IW'(re), IW'(im)};
    fft_valid_il = v;
    fft_last_il  = l;
    tick();
  endtask

  task automatic send(input int base, input bit gapped, input bit use_last);
    for (int k = 0; k < NFFT; k++) begin
      drive(base + k, -(base + k), 1'b1, use_last && (k == NFFT-1));
      if (gapped && k != NFFT-1) drive(0, 0, 1'b0, 1'b0);
    end
    fft_valid_il = 1'b0;
    fft_last_il  = 1'b0;
  endtask

  // called at the negedge right after the frame-end edge E0
  task automatic burst(input string tag, input int base);
    logic [IW-1:0] er;
    logic [IW-1:0] ei;
    chk({tag, "_v_e0"}, 64'(valid_ol), 64'(0));
    tick();
    chk({tag, "_v_e1"}, 64'(valid_ol), 64'(0));
    for (int b = 0; b <= NFFT/2; b++) begin
      tick();
      er = IW'(base + perm[b]);
      ei = IW'(-(base + perm[b]));
      chk({tag, "_valid"}, 64'(valid_ol), 64'(1));
      chk({tag, "_bin"},   64'(bin_ol),   64'(b));
      chk({tag, "_real"},  64'(real_ol),  64'(er));
      chk({tag, "_imag"},  64'(imag_ol),  64'(ei));
      chk({tag, "_last"},  64'(last_ol),  64'(b == NFFT/2));
      chk({tag, "_err"},   64'(err_ol),   64'(0));
    end
    tick();
    chk({tag, "_v_end"}, 64'(valid_ol), 64'(0));
  endtask

  initial begin
    int v0;
    int e0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(valid_ol), 64'(0));
    chk("rst_last",  64'(last_ol),  64'(0));
    chk("rst_err",   64'(err_ol),   64'(0));
    chk("rst_real",  64'(real_ol),  64'(0));
    chk("rst_imag",  64'(imag_ol),  64'(0));
    chk("rst_bin",   64'(bin_ol),   64'(0));
    rst = 1'b0;
    tick();

    // single frame
    send(0, 1'b0, 1'b1);
    burst("single", 0);
    tick();

    // back-to-back frames at full rate
    v0 = vcnt;
    e0 = ecnt;
    q_re.delete();
    q_cyc.delete();
    send(0, 1'b0, 1'b1);
    send(100, 1'b0, 1'b1);
    repeat (14) tick();
    chk("b2b_count", 64'(q_re.size()), 64'(10));
    if (q_re.size() == 10) begin
      for (int i = 0; i < 5; i++) begin
        chk("b2b_realA", 64'(q_re[i]),   64'(perm[i]));
        chk("b2b_realB", 64'(q_re[i+5]), 64'(100 + perm[i]));
      end
      chk("b2b_runA", 64'(q_cyc[4] - q_cyc[0]), 64'(4));
      chk("b2b_gap",  64'(q_cyc[5] - q_cyc[4]), 64'(4));
      chk("b2b_runB", 64'(q_cyc[9] - q_cyc[5]), 64'(4));
    end
    chk("b2b_err", 64'(ecnt - e0), 64'(0));

    // gapped input
    send(0, 1'b1, 1'b1);
    burst("gapped", 0);
    tick();

    // early last on 4th sample
    v0 = vcnt;
    e0 = ecnt;
    drive(0, 0, 1'b1, 1'b0);
    drive(1, -1, 1'b1, 1'b0);
    drive(2, -2, 1'b1, 1'b0);
    drive(3, -3, 1'b1, 1'b1);
    fft_valid_il = 1'b0;
    fft_last_il  = 1'b0;
    chk("early_err_hi", 64'(err_ol), 64'(1));
    tick();
    chk("early_err_lo", 64'(err_ol), 64'(0));
    repeat (10) tick();
    chk("early_novalid", 64'(vcnt - v0), 64'(0));
    chk("early_errcnt",  64'(ecnt - e0), 64'(1));
    send(0, 1'b0, 1'b1);
    burst("after_early", 0);
    tick();

    // missing last
    v0 = vcnt;
    e0 = ecnt;
    send(0, 1'b0, 1'b0);
    chk("miss_err_hi", 64'(err_ol), 64'(1));
    tick();
    chk("miss_err_lo", 64'(err_ol), 64'(0));
    repeat (10) tick();
    chk("miss_novalid", 64'(vcnt - v0), 64'(0));
    chk("miss_errcnt",  64'(ecnt - e0), 64'(1));
    send(0, 1'b0, 1'b1);
    burst("after_miss", 0);
    tick();

    // reset mid-read
    send(0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk("mid_bin2",   64'(bin_ol),   64'(2));
    chk("mid_valid2", 64'(valid_ol), 64'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(valid_ol), 64'(0));
    chk("mid_rst_real",  64'(real_ol),  64'(0));
    chk("mid_rst_imag",  64'(imag_ol),  64'(0));
    chk("mid_rst_bin",   64'(bin_ol),   64'(0));
    chk("mid_rst_last",  64'(last_ol),  64'(0));
    chk("mid_rst_err",   64'(err_ol),   64'(0));
    rst = 1'b0;
    v0 = vcnt;
    repeat (6) tick();
    chk("mid_lost", 64'(vcnt - v0), 64'(0));
    send(0, 1'b0, 1'b1);
    burst("after_rst", 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
